// File: rtl/axi4_pkg.sv
// Shared AXI4 read-channel types and constants used by the memory responders.
package axi4_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int ID_W     = 4;
  localparam int SIZE_MAX = $clog2(DATA_W / 8);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic ACLK;
    logic ARESETn;
  } common;

  typedef struct packed {
    logic              ARVALID;
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
  } ar_m;

  typedef struct packed {
    logic ARREADY;
  } ar_s;

  typedef struct packed {
    logic RREADY;
  } r_m;

  typedef struct packed {
    logic              RVALID;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
  } r_s;

  // Burst-wide errors: oversize beats, reserved type, or an illegal wrap length.
  function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (int'(size) > SIZE_MAX) || (burst == 2'b11) || bad_wrap;
  endfunction
endpackage

// File: rtl/axi4_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
module axi4_burst_addr
  import axi4_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [7:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] addr_o
);
  logic [ADDR_W-1:0] step, inc, mask;

  always_comb begin
    step = ADDR_W'(1) << size_i;
    inc  = addr_i + step;
    mask = (step * (ADDR_W'(len_i) + ADDR_W'(1))) - ADDR_W'(1);
    case (burst_i)
      BURST_INCR: addr_o = inc;
      BURST_WRAP: addr_o = (addr_i & ~mask) | (inc & mask);
      default:    addr_o = addr_i;
    endcase
  end
endmodule

// File: rtl/axi4_rd_mem.sv
// AXI4 read-only memory responder: one AR burst at a time, one R beat per cycle.
module axi4_rd_mem
  import axi4_pkg::*;
#(
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter string             INIT_FILE = ""
) (
  input  common AXI_COMMON,
  input  ar_m   AXI_AR_M,
  output ar_s   AXI_AR_S,
  input  r_m    AXI_R_M,
  output r_s    AXI_R_S
);
  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam int BSH   = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * (DATA_W / 8));

  logic clk, rst_n;
  assign clk   = AXI_COMMON.ACLK;
  assign rst_n = AXI_COMMON.ARESETn;

  logic [DATA_W-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        len_q, len_d, cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [ADDR_W-1:0] addr_q, addr_d, nxt_addr;
  logic              err_q, err_d;
  r_s                r_q, r_d;

  axi4_burst_addr u_addr (
    .addr_i  (addr_q),
    .size_i  (size_q),
    .len_i   (len_q),
    .burst_i (burst_q),
    .addr_o  (nxt_addr)
  );

  // Below-base addresses borrow into bit ADDR_W, so one compare covers both ends.
  function automatic r_s fetch(input logic [ADDR_W-1:0] a, input logic berr,
                               input logic [ID_W-1:0] id, input logic last);
    logic [ADDR_W:0] off;
    r_s b;
    off     = {1'b0, a} - {1'b0, BASE_ADDR};
    b       = '0;
    b.RVALID = 1'b1;
    b.RID    = id;
    b.RLAST  = last;
    if (berr || off >= MEM_BYTES) b.RRESP = RESP_SLVERR;
    else                          b.RDATA = mem[off[BSH +: IDX_W]];
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: if (AXI_AR_M.ARVALID) begin
        id_d    = AXI_AR_M.ARID;
        len_d   = AXI_AR_M.ARLEN;
        size_d  = AXI_AR_M.ARSIZE;
        burst_d = AXI_AR_M.ARBURST;
        addr_d  = AXI_AR_M.ARADDR;
        err_d   = burst_err(AXI_AR_M.ARLEN, AXI_AR_M.ARSIZE, AXI_AR_M.ARBURST);
        cnt_d   = '0;
        r_d     = fetch(AXI_AR_M.ARADDR, err_d, AXI_AR_M.ARID, AXI_AR_M.ARLEN == 8'd0);
        state_d = S_BURST;
      end
      S_BURST: if (AXI_R_M.RREADY) begin
        if (r_q.RLAST) begin
          r_d.RVALID = 1'b0;
          state_d    = S_IDLE;
        end else begin
          addr_d = nxt_addr;
          cnt_d  = cnt_q + 8'd1;
          r_d    = fetch(nxt_addr, err_q, id_q, cnt_d == len_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  assign AXI_AR_S.ARREADY = (state_q == S_IDLE);
  assign AXI_R_S          = r_q;
endmodule

// File: tb/tb_axi4_rd_mem.sv
// Directed bench for axi4_rd_mem with a 16-word memory preloaded with a known pattern.
module tb_axi4_rd_mem;
  import axi4_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  common cm;
  ar_m   arm;
  ar_s   ars;
  r_m    rm;
  r_s    rs;

  assign cm = '{ACLK: clk, ARESETn: rst_n};
  always #5 clk = ~clk;

  axi4_rd_mem #(.DEPTH(16), .BASE_ADDR(32'h0), .INIT_FILE("")) dut (
    .AXI_COMMON (cm),
    .AXI_AR_M   (arm),
    .AXI_AR_S   (ars),
    .AXI_R_M    (rm),
    .AXI_R_S    (rs)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] gd [16];
  logic [1:0]  gr [16];
  logic        gl [16];
  logic [3:0]  gi [16];
  int nb;
  bit to, hold_bad, first_ok;

  function automatic logic [31:0] memval(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h11;
  endfunction

  task automatic set_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    arm.ARVALID = 1'b1;
    arm.ARID    = id;
    arm.ARADDR  = addr;
    arm.ARLEN   = len;
    arm.ARSIZE  = size;
    arm.ARBURST = burst;
  endtask

  // Issues one AR and collects beats under an RREADY pattern (bit k = cycle k).
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [15:0] rr);
    int cyc, k;
    bit stalled, done;
    r_s snap;
    nb = 0; to = 0; hold_bad = 0; first_ok = 0; stalled = 0; done = 0;
    set_ar(id, addr, len, size, burst);
    cyc = 0;
    while (!ars.ARREADY && cyc < 20) begin @(negedge clk); cyc++; end
    if (cyc >= 20) begin to = 1; arm.ARVALID = 1'b0; return; end
    @(negedge clk);
    arm.ARVALID = 1'b0;
    first_ok = rs.RVALID;
    k = 0;
    while (!done && k < 64) begin
      if (stalled && rs !== snap) hold_bad = 1;
      rm.RREADY = rr[k[3:0]];
      stalled = rs.RVALID && !rm.RREADY;
      snap = rs;
      if (rs.RVALID && rm.RREADY && nb < 16) begin
        gd[nb] = rs.RDATA; gr[nb] = rs.RRESP; gl[nb] = rs.RLAST; gi[nb] = rs.RID;
        nb++;
        done = rs.RLAST;
      end
      @(negedge clk);
      k++;
    end
    rm.RREADY = 1'b0;
    if (!done) to = 1;
  endtask

  task automatic test_reset();
    set_ar(4'd1, 32'h10, 8'd0, 3'd2, BURST_INCR);
    rm.RREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (ars.ARREADY !== 1'b0) begin fails++; $display("FAIL reset_arready got %b exp 0", ars.ARREADY); end
    end
    tests++;
    if (rs !== '0) begin fails++; $display("FAIL reset_r got %h exp 0", rs); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (ars.ARREADY !== 1'b1) begin fails++; $display("FAIL post_reset_arready got %b exp 1", ars.ARREADY); end
    @(negedge clk);
    arm.ARVALID = 1'b0;
    tests++;
    if (rs.RVALID !== 1'b1 || rs.RDATA !== memval(4) || rs.RLAST !== 1'b1 || rs.RID !== 4'd1 || ars.ARREADY !== 1'b0) begin
      fails++; $display("FAIL first_burst got v=%b d=%h l=%b id=%h ar=%b exp v=1 d=%h l=1 id=1 ar=0",
                        rs.RVALID, rs.RDATA, rs.RLAST, rs.RID, ars.ARREADY, memval(4));
    end
    @(negedge clk);
    rm.RREADY = 1'b0;
    tests++;
    if (rs.RVALID !== 1'b0 || ars.ARREADY !== 1'b1) begin
      fails++; $display("FAIL first_burst_end got v=%b ar=%b exp v=0 ar=1", rs.RVALID, ars.ARREADY);
    end
  endtask

  task automatic test_incr_stall();
    run_burst(4'd5, 32'h10, 8'd3, 3'd2, BURST_INCR, 16'hFFED);
    tests++;
    if (to || nb != 4 || !first_ok || hold_bad) begin
      fails++; $display("FAIL incr_shape got to=%b nb=%0d first=%b holdbad=%b exp 0 4 1 0", to, nb, first_ok, hold_bad);
    end
    for (int b = 0; b < 4; b++) begin
      tests++;
      if (gd[b] !== memval(4 + b) || gi[b] !== 4'd5 || gr[b] !== RESP_OKAY || gl[b] !== (b == 3)) begin
        fails++; $display("FAIL incr_beat%0d got d=%h id=%h r=%b l=%b exp d=%h id=5 r=00 l=%b",
                          b, gd[b], gi[b], gr[b], gl[b], memval(4 + b), b == 3);
      end
    end
    tests++;
    if (rs.RVALID !== 1'b0 || ars.ARREADY !== 1'b1) begin
      fails++; $display("FAIL incr_end got v=%b ar=%b exp v=0 ar=1", rs.RVALID, ars.ARREADY);
    end
  endtask

  task automatic test_wrap();
    int exp_idx [4] = '{14, 15, 12, 13};
    run_burst(4'd6, 32'h38, 8'd3, 3'd2, BURST_WRAP, 16'hFFFF);
    tests++;
    if (to || nb != 4) begin fails++; $display("FAIL wrap_shape got to=%b nb=%0d exp 0 4", to, nb); end
    for (int b = 0; b < 4; b++) begin
      tests++;
      if (gd[b] !== memval(exp_idx[b]) || gr[b] !== RESP_OKAY || gl[b] !== (b == 3) || gi[b] !== 4'd6) begin
        fails++; $display("FAIL wrap_beat%0d got d=%h r=%b l=%b exp d=%h r=00 l=%b",
                          b, gd[b], gr[b], gl[b], memval(exp_idx[b]), b == 3);
      end
    end
  endtask

  task automatic test_fixed();
    run_burst(4'd7, 32'h20, 8'd2, 3'd2, BURST_FIXED, 16'hFFFF);
    tests++;
    if (to || nb != 3) begin fails++; $display("FAIL fixed_shape got to=%b nb=%0d exp 0 3", to, nb); end
    for (int b = 0; b < 3; b++) begin
      tests++;
      if (gd[b] !== memval(8) || gr[b] !== RESP_OKAY || gl[b] !== (b == 2)) begin
        fails++; $display("FAIL fixed_beat%0d got d=%h r=%b l=%b exp d=%h r=00 l=%b",
                          b, gd[b], gr[b], gl[b], memval(8), b == 2);
      end
    end
  endtask

  task automatic test_oor();
    run_burst(4'd8, 32'h3C, 8'd1, 3'd2, BURST_INCR, 16'hFFFF);
    tests++;
    if (to || nb != 2) begin fails++; $display("FAIL oor_shape got to=%b nb=%0d exp 0 2", to, nb); end
    tests++;
    if (gd[0] !== memval(15) || gr[0] !== RESP_OKAY || gl[0] !== 1'b0) begin
      fails++; $display("FAIL oor_beat0 got d=%h r=%b l=%b exp d=%h r=00 l=0", gd[0], gr[0], gl[0], memval(15));
    end
    tests++;
    if (gd[1] !== 32'h0 || gr[1] !== RESP_SLVERR || gl[1] !== 1'b1) begin
      fails++; $display("FAIL oor_beat1 got d=%h r=%b l=%b exp d=0 r=10 l=1", gd[1], gr[1], gl[1]);
    end
  endtask

  task automatic test_burst_errors();
    // size too big, illegal wrap length, reserved burst type
    logic [2:0] sz [3] = '{3'd3, 3'd2, 3'd2};
    logic [7:0] ln [3] = '{8'd1, 8'd2, 8'd0};
    logic [1:0] bt [3] = '{BURST_INCR, BURST_WRAP, 2'b11};
    for (int t = 0; t < 3; t++) begin
      run_burst(4'd9, 32'h0, ln[t], sz[t], bt[t], 16'hFFFF);
      tests++;
      if (to || nb != int'(ln[t]) + 1) begin
        fails++; $display("FAIL err%0d_shape got to=%b nb=%0d exp 0 %0d", t, to, nb, int'(ln[t]) + 1);
      end
      for (int b = 0; b < nb && b < 16; b++) begin
        tests++;
        if (gd[b] !== 32'h0 || gr[b] !== RESP_SLVERR || gl[b] !== (b == int'(ln[t]))) begin
          fails++; $display("FAIL err%0d_beat%0d got d=%h r=%b l=%b exp d=0 r=10 l=%b",
                            t, b, gd[b], gr[b], gl[b], b == int'(ln[t]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    set_ar(4'd2, 32'h0, 8'd1, 3'd2, BURST_INCR);
    rm.RREADY = 1'b1;
    @(negedge clk);
    set_ar(4'd3, 32'h8, 8'd0, 3'd2, BURST_INCR);
    tests++;
    if (rs.RVALID !== 1'b1 || rs.RDATA !== memval(0) || ars.ARREADY !== 1'b0) begin
      fails++; $display("FAIL b2b_beat0 got v=%b d=%h ar=%b exp v=1 d=%h ar=0", rs.RVALID, rs.RDATA, ars.ARREADY, memval(0));
    end
    @(negedge clk);
    tests++;
    if (rs.RDATA !== memval(1) || rs.RLAST !== 1'b1 || ars.ARREADY !== 1'b0) begin
      fails++; $display("FAIL b2b_beat1 got d=%h l=%b ar=%b exp d=%h l=1 ar=0", rs.RDATA, rs.RLAST, ars.ARREADY, memval(1));
    end
    @(negedge clk);
    tests++;
    if (rs.RVALID !== 1'b0 || ars.ARREADY !== 1'b1) begin
      fails++; $display("FAIL b2b_gap got v=%b ar=%b exp v=0 ar=1", rs.RVALID, ars.ARREADY);
    end
    @(negedge clk);
    arm.ARVALID = 1'b0;
    tests++;
    if (rs.RVALID !== 1'b1 || rs.RID !== 4'd3 || rs.RDATA !== memval(2) || rs.RLAST !== 1'b1 || ars.ARREADY !== 1'b0) begin
      fails++; $display("FAIL b2b_second got v=%b id=%h d=%h l=%b ar=%b exp v=1 id=3 d=%h l=1 ar=0",
                        rs.RVALID, rs.RID, rs.RDATA, rs.RLAST, ars.ARREADY, memval(2));
    end
    @(negedge clk);
    rm.RREADY = 1'b0;
    tests++;
    if (rs.RVALID !== 1'b0) begin fails++; $display("FAIL b2b_second_end got v=%b exp 0", rs.RVALID); end
  endtask

  task automatic test_mid_reset();
    set_ar(4'd4, 32'h0, 8'd7, 3'd2, BURST_INCR);
    rm.RREADY = 1'b1;
    @(negedge clk);
    arm.ARVALID = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (rs.RVALID !== 1'b1 || rs.RDATA !== memval(2)) begin
      fails++; $display("FAIL midrst_beat2 got v=%b d=%h exp v=1 d=%h", rs.RVALID, rs.RDATA, memval(2));
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (rs !== '0 || ars.ARREADY !== 1'b0) begin
      fails++; $display("FAIL midrst_clear got r=%h ar=%b exp r=0 ar=0", rs, ars.ARREADY);
    end
    rm.RREADY = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(4'd10, 32'h10, 8'd1, 3'd2, BURST_INCR, 16'hFFFF);
    tests++;
    if (to || nb != 2 || gd[0] !== memval(4) || gd[1] !== memval(5) || gi[1] !== 4'd10 || gl[1] !== 1'b1) begin
      fails++; $display("FAIL midrst_fresh got to=%b nb=%0d d0=%h d1=%h id=%h l=%b exp 0 2 %h %h a 1",
                        to, nb, gd[0], gd[1], gi[1], gl[1], memval(4), memval(5));
    end
  endtask

  initial begin
    arm = '0;
    rm  = '0;
    #1;
    for (int i = 0; i < 16; i++) dut.mem[i] = memval(i);
    test_reset();
    test_incr_stall();
    test_wrap();
    test_fixed();
    test_oor();
    test_burst_errors();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
